// File: rtl/mul_div_unit_if.sv
// Operand, control and result bundle for the iterative multiply/divide unit.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src1, src2, flush, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, src1, src2, flush, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add for mult, restoring step for div.
module mul_div_unit (
    input  logic          clk,
    input  logic          resetn,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  cnt_r;
    logic        is_div_r;
    logic        res_neg_r;
    logic        rem_neg_r;
    logic        dz_r;
    logic [31:0] opnd_r;
    logic [63:0] acc_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        start_acc_s;
    logic        signed_s;
    logic        div_zero_in_s;
    logic        commit_s;
    logic [31:0] mag1_s;
    logic [31:0] mag2_s;
    logic [32:0] mul_sum_s;
    logic [32:0] rem_shl_s;
    logic [32:0] rem_diff_s;
    logic [63:0] step_s;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        cond_neg32 = en ? (32'd0 - v) : v;
    endfunction

    // Operand magnitudes and start acceptance decode
    always_comb begin
        start_acc_s   = (state_r == IDLE) && bus.start;
        signed_s      = ~bus.op[0];
        mag1_s        = cond_neg32(bus.src1, signed_s && bus.src1[31]);
        mag2_s        = cond_neg32(bus.src2, signed_s && bus.src2[31]);
        div_zero_in_s = bus.op[1] && (bus.src2 == 32'd0);
    end

    // One iteration step; bit 32 of the trial difference is the restoring borrow
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        rem_shl_s  = acc_r[63:31];
        rem_diff_s = rem_shl_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (rem_diff_s[32]) begin
                step_s = {acc_r[62:0], 1'b0};
            end else begin
                step_s = {rem_diff_s[31:0], acc_r[30:0], 1'b1};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    // Sign fix-up of the finished magnitudes; remainder takes the dividend sign
    always_comb begin
        prod_s = res_neg_r ? (64'd0 - acc_r) : acc_r;
        quo_s  = cond_neg32(acc_r[31:0], res_neg_r);
        rem_s  = cond_neg32(acc_r[63:32], rem_neg_r);
        if (is_div_r) begin
            res_hi_s = rem_s;
            res_lo_s = quo_s;
        end else begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
        commit_s = (state_r == DONE) && !bus.flush && !dz_r;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_acc_s) begin
                    if (div_zero_in_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 5'd31) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, iteration counter and working accumulator
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= 5'd0;
            is_div_r  <= 1'b0;
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            dz_r      <= 1'b0;
            opnd_r    <= 32'd0;
            acc_r     <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 5'd0;
                    if (start_acc_s) begin
                        is_div_r  <= bus.op[1];
                        res_neg_r <= signed_s && (bus.src1[31] ^ bus.src2[31]);
                        rem_neg_r <= signed_s && bus.src1[31];
                        dz_r      <= div_zero_in_s;
                        opnd_r    <= bus.op[1] ? mag2_s : mag1_s;
                        acc_r     <= {32'd0, (bus.op[1] ? mag1_s : mag2_s)};
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        cnt_r <= 5'd0;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                        acc_r <= step_s;
                    end
                end
                DONE:    cnt_r <= 5'd0;
                default: cnt_r <= 5'd0;
            endcase
        end
    end

    // Architectural HI/LO: result commit wins over a direct write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (state_r == IDLE) begin
            if (bus.hi_we) begin
                hi_r <= bus.wdata;
            end
            if (bus.lo_we) begin
                lo_r <= bus.wdata;
            end
        end
    end

    assign bus.busy     = (state_r != IDLE);
    assign bus.done     = (state_r == DONE) && !bus.flush;
    assign bus.div_zero = (state_r == DONE) && !bus.flush && dz_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: arithmetic reference model, queued
// expectations and an independent monitor that checks each committed result.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    exp_t        mon_e;
    logic        mon_dz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic, returns {hi, lo}
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin
                sr = sa * sb;
                up = sr;
            end
            2'b01: up = ua * ub;
            2'b10: begin
                sr = sa / sb;
                up[31:0] = sr[31:0];
                sr = sa % sb;
                up[63:32] = sr[31:0];
            end
            default: begin
                up[31:0]  = 32'(ua / ub);
                up[63:32] = 32'(ua % ub);
            end
        endcase
        return up;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: result appears on hi/lo one cycle after the done pulse
    always begin
        @(negedge clk);
        if (resetn && !bus.done && bus.div_zero) begin
            checks++;
            failures++;
            $display("FAIL div_zero_without_done actual=1 required=0");
        end
        if (resetn && bus.done) begin
            mon_dz = bus.div_zero;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done required=no_done");
            end else begin
                mon_e = exp_q.pop_front();
                check("div_zero_flag", {63'd0, mon_dz}, {63'd0, mon_e.dz});
                check("hi_result", {32'd0, bus.hi}, {32'd0, mon_e.hi});
                check("lo_result", {32'd0, bus.lo}, {32'd0, mon_e.lo});
            end
        end
    end

    // mode 0 normal, 1 poke start/hi_we/lo_we while busy, 2 reset at CALC count 20
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input logic with_flush, input logic with_wr);
        int          lat;
        int          exp_lat;
        logic [63:0] r;
        logic [31:0] wv;
        exp_t        e;
        wv = $urandom;
        exp_lat = 33;
        if (mode != 2) begin
            if (with_wr) m_hi = wv;
            if (op[1] && (b == 32'd0)) begin
                exp_lat = 1;
                e = '{m_hi, m_lo, 1'b1};
            end else begin
                r = ref_model(op, a, b);
                m_hi = r[63:32];
                m_lo = r[31:0];
                e = '{m_hi, m_lo, 1'b0};
            end
            exp_q.push_back(e);
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
        bus.flush = with_flush;
        bus.hi_we = with_wr;
        bus.wdata = wv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.op    = 2'($urandom);
        bus.src1  = $urandom;
        bus.src2  = $urandom;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mode == 2 && k == 21) begin
                resetn = 1'b0;
                #1;
                m_hi = 32'd0;
                m_lo = 32'd0;
                check("reset_busy", {63'd0, bus.busy}, 64'd0);
                check("reset_done", {63'd0, bus.done}, 64'd0);
                check("reset_hi", {32'd0, bus.hi}, 64'd0);
                check("reset_lo", {32'd0, bus.lo}, 64'd0);
                lat = -1;
                break;
            end
            if (mode == 1 && k == 5) begin
                bus.start = 1'b1;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = $urandom;
            end else if (mode == 1 && k == 6) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        if (mode == 2) begin
            @(negedge clk);
            resetn = 1'b1;
        end else if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=%0d", exp_lat);
            if (exp_q.size() != 0) void'(exp_q.pop_back());
        end else begin
            check("latency", 64'(lat), 64'(exp_lat));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic to_hi, input logic [31:0] v);
        bus.hi_we = to_hi;
        bus.lo_we = ~to_hi;
        bus.wdata = v;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (to_hi) m_hi = v;
        else m_lo = v;
        check("direct_write_hi", {32'd0, bus.hi}, {32'd0, m_hi});
        check("direct_write_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.src1  = 32'd0;
        bus.src2  = 32'd0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_div_zero", {63'd0, bus.div_zero}, 64'd0);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, 1'b0);
        check("mult_neg3x5", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
        check("div_neg7by2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("divu_big", {bus.hi, bus.lo}, 64'h8000_0000_0000_0000);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("div_overflow", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        write_reg(1'b1, 32'h0000_1234);
        write_reg(1'b0, 32'h0000_5678);
        issue(2'b11, 32'd100, 32'd0, 0, 1'b0, 1'b0);
        check("divu_zero_keep", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
        issue(2'b10, 32'd5, 32'd0, 0, 1'b0, 1'b1);
        issue(2'b01, $urandom, $urandom, 0, 1'b0, 1'b1);
        issue(2'b01, 32'd11, 32'd13, 0, 1'b1, 1'b0);

        // Flush at CALC count 10, then restart one cycle later
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src1  = 32'd7;
        bus.src2  = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_busy", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_done", {63'd0, bus.done}, 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
        issue(2'b00, 32'd7, 32'd9, 0, 1'b0, 1'b0);

        issue(2'b01, 32'd3, 32'd4, 1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), rnd_opnd(), rnd_opnd(), 0, 1'b0, 1'b0);
        end

        issue(2'b00, 32'd7, 32'd9, 2, 1'b0, 1'b0);
        issue(2'b10, 32'hFFFF_FF00, 32'd7, 0, 1'b0, 1'b0);

        repeat (40) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 mult, 01 multu, 10 div, 11 divu; captured with start.
REQ-006 src1  input  32  multiplicand or dividend; captured with start.
REQ-007 src2  input  32  multiplier or divisor; captured with start.
REQ-008 flush  input  1  cancel the operation in flight (pipeline flush).
REQ-009 hi_we / lo_we  input  1 each  direct write to HI / LO (mthi / mtlo).
REQ-010 wdata  input  32  data for hi_we / lo_we.
REQ-011 busy  output  1  high in CALC and DONE; the EX stage stalls on it.
REQ-012 done  output  1  one-cycle pulse when the result commits.
REQ-013 div_zero  output  1  one-cycle pulse, coincident with done, for div/divu with src2 equal to 0.
REQ-014 hi / lo  output  32 each  architectural HI and LO registers.

Function
REQ-015 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch op, src1 and src2; the next state SHALL be CALC, or DONE directly for a divide with src2=0.
REQ-017 CALC SHALL run exactly 32 cycles, using a 5-bit counter from 0 to 31; on count 31 the next state SHALL be DONE.
- Multiply: one radix-2 shift-add step per cycle.
- Divide: one restoring-division step per cycle.
REQ-018 In DONE, hi and lo SHALL update on the exiting edge, and done SHALL be 1 for that one cycle; the next state SHALL be IDLE.
- Total latency: start sampled at edge N gives done high during cycle N+33.
- Divide by zero: done high during cycle N+1.
REQ-019 Signed operations SHALL use unsigned magnitudes internally.
- Product sign: src1[31] XOR src2[31].
- Quotient sign: src1[31] XOR src2[31].
- Remainder sign: follows the dividend.
REQ-020 Multiply results: hi = product[63:32], lo = product[31:0].
REQ-021 Divide results: lo = quotient, hi = remainder.
REQ-022 Divide by zero SHALL leave hi and lo unchanged and pulse div_zero.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0x00000000, with no flag.
REQ-024 start SHALL be ignored while busy=1, with no queuing.
REQ-025 flush=1 in CALC or DONE SHALL force IDLE at the next edge, leave hi and lo unchanged, and suppress done; flush in IDLE SHALL have no effect.
REQ-026 If flush and start are both high in IDLE, start SHALL be accepted.
REQ-027 hi_we / lo_we SHALL write wdata at the next edge only when busy=0; they SHALL be ignored while busy=1.
- If a write coincides with an accepted start, the write SHALL take effect and the later result SHALL overwrite it.
REQ-028 Operands latched at start SHALL be used for the whole operation; later changes on src1 and src2 SHALL have no effect.
REQ-029 The block SHALL use no combinational path from start to busy; busy SHALL derive from registered state.

Reset
REQ-030 resetn=0 SHALL immediately force the following, at any time including mid-operation, with no done pulse:
- state = IDLE, counter = 0
- busy = 0, done = 0, div_zero = 0
- hi = 0x00000000, lo = 0x00000000
REQ-031 After resetn deasserts, the first start SHALL be accepted at the first rising edge at which it is sampled high.

Verification
REQ-032 mult, src1=0xFFFFFFFD (-3), src2=5 -> done in cycle N+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 multu, src1=src2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 div, src1=0xFFFFFFF9 (-7), src2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu 0x80000000/0xFFFFFFFF -> lo=0, hi=0x80000000.
REQ-035 divu, src1=100, src2=0, with hi=0x1234/lo=0x5678 preset via hi_we/lo_we -> done and div_zero high in cycle N+1; hi=0x1234, lo=0x5678 unchanged.
REQ-036 Flush test: mult 7*9 started, flush at CALC count 10 -> busy=0 next cycle, no done, hi/lo keep prior values; a new start one cycle later is accepted.
REQ-037 Reset test: resetn pulsed low during CALC count 20 -> busy=0 and hi=lo=0 immediately; start during busy and hi_we during busy -> both ignored.
